reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 register bank between two writeback requesters:
//  REQ0 = ALU/EX result, REQ1 = memory-load return.
//  Round-robin grant, valid/ready handshake, one registered write stage driving AW/DIN/REG_WRITE.
//  Sits between the pipeline writeback sources and reg_bank.
// PARAMETERS
//  ADDR_W    5   register address width (32 registers)
//  DATA_W    32  register data width
//  ZERO_REG  0   hard-wired zero register; writes to it are accepted and dropped
// PORTS
//  CLK         in   1       clock, all state on rising edge
//  RST         in   1       synchronous, active-high reset
//  FREEZE      in   1       1 = no grants this cycle (bank owner stall)
//  REQ0_VALID  in   1       requester 0 has a write pending
//  REQ0_ADDR   in   ADDR_W  requester 0 destination register
//  REQ0_DATA   in   DATA_W  requester 0 write data
//  REQ0_READY  out  1       requester 0 granted this cycle (combinational)
//  REQ1_VALID/REQ1_ADDR/REQ1_DATA/REQ1_READY  same for requester 1
//  AW          out  ADDR_W  registered write address to bank
//  DIN         out  DATA_W  registered write data to bank
//  REG_WRITE   out  1       registered write enable to bank
// BEHAVIOUR
//  - Transfer on VALID & READY in the same cycle. Requester holds ADDR/DATA stable while VALID & !READY.
//  - READY is never asserted without its VALID. At most one READY per cycle.
//  - FREEZE=1 forces both READY=0. The write stage still drains its current entry.
//  - Arbitration:
//    - One VALID: that requester is granted.
//    - Both VALID: grant the requester selected by the RR pointer PRI (0 or 1).
//  - PRI update: after any grant, PRI <= ~granted index. No grant -> PRI unchanged.
//  - Write stage latency = 1:
//    - A grant in cycle N sets AW/DIN in N+1.
//    - REG_WRITE in N+1 = 1 iff the granted ADDR != ZERO_REG.
//  - No grant in cycle N -> REG_WRITE=0 in N+1; AW/DIN hold their previous values.
//  - Write stage never back-pressures: one grant per cycle max, stage emptied every cycle.
//  - Reset (any cycle, including a held request):
//    - AW=0, DIN=0, REG_WRITE=0, PRI=0.
//    - READY outputs are 0 while RST=1.
//    - An un-granted request stays pending at its source; the arbiter keeps no copy.
//  - Same-address writes in consecutive cycles are both issued in grant order (last wins in the bank).
// CONFIGURATION
//  REG_WB_BYPASS_EN defined:
//  - Adds inputs RD_ADDR1, RD_ADDR2 (ADDR_W) and outputs BYP_HIT1, BYP_HIT2 (1), BYP_DATA1, BYP_DATA2 (DATA_W).
//  - BYP_HITk = REG_WRITE & (AW == RD_ADDRk) & (RD_ADDRk != ZERO_REG). BYP_DATAk = DIN when hit, else 0.
//  - Combinational; lets readers see the in-flight write in the same cycle it reaches the bank.
//  REG_WB_BYPASS_EN undefined: the bypass ports do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package reg_bank_pkg: ADDR_W, DATA_W, ZERO_REG constants; typedef wb_req_t {addr, data}.
//  - Sub-module rr_arb2 (2-way round-robin: valid[1:0], freeze -> grant[1:0], owns PRI).
//  - Top holds the input mux, zero-register filter, write stage and the optional bypass.
// TESTING
//  1 Reset: assert RST with REQ0 valid -> REQ0_READY=0 throughout. Next cycle after release: REG_WRITE=0, AW=0, DIN=0, PRI=0.
//  2 Single requester: REQ1 {addr=5, data=0xDEADBEEF} -> READY1 in cycle N; cycle N+1: AW=5, DIN=0xDEADBEEF, REG_WRITE=1.
//  3 Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; REG_WRITE=1 on 4 consecutive cycles.
//  4 Zero register: REQ0 addr=0, data=0x1234 -> READY0=1; next cycle REG_WRITE=0; PRI flips to 1.
//  5 FREEZE: both valid, FREEZE=1 for 3 cycles -> no READY, REG_WRITE=0; after release the grant follows the unchanged PRI.
//  6 REG_WB_BYPASS_EN: write r7=0x55 granted. Next cycle RD_ADDR1=7 -> BYP_HIT1=1, BYP_DATA1=0x55. RD_ADDR2=0 -> BYP_HIT2=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and the writeback request type for the register bank
// write path. Imported by rr_arb2 and reg_wb_arbiter.
package reg_bank_pkg;

    localparam int ADDR_W = 5;   // 32 registers
    localparam int DATA_W = 32;

    // Hard-wired zero register: writes to it are accepted and dropped.
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Owns the priority pointer; grants at most one
// valid requester per cycle, nothing while frozen or in reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // Requester favoured when both are valid (0 or 1).
    logic pri;

    // Pick the winner: a lone requester wins, contention goes to pri.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant = 2'b00;
        if (!rst && !freeze) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = pri ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Hand priority to the other side after each grant; hold it otherwise.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pri <= 1'b0;
        end else if (grant[0]) begin
            pri <= 1'b1;
        end else if (grant[1]) begin
            pri <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the single register-bank write port.
// REQ0 = ALU/EX result, REQ1 = memory-load return. Round-robin grant,
// one registered write stage driving AW/DIN/REG_WRITE.
// Optional feature: define REG_WB_BYPASS_EN to add same-cycle read bypass
// ports (RD_ADDR1/2 in, BYP_HIT1/2 and BYP_DATA1/2 out).
module reg_wb_arbiter
    import reg_bank_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              FREEZE,
    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic [ADDR_W-1:0] AW,
    output logic [DATA_W-1:0] DIN,
    output logic              REG_WRITE
`ifdef REG_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] RD_ADDR1,
    input  logic [ADDR_W-1:0] RD_ADDR2,
    output logic              BYP_HIT1,
    output logic              BYP_HIT2,
    output logic [DATA_W-1:0] BYP_DATA1,
    output logic [DATA_W-1:0] BYP_DATA2
`endif
);

    logic [1:0] grant;
    wb_req_t    req0;
    wb_req_t    req1;
    wb_req_t    sel;
    logic       any_grant;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .freeze (FREEZE),
        .valid  ({REQ1_VALID, REQ0_VALID}),
        .grant  (grant)
    );

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];
    assign any_grant  = |grant;

    // Bundle each requester's payload and steer the granted one to the stage.
    always_comb begin
        req0.addr = REQ0_ADDR;
        req0.data = REQ0_DATA;
        req1.addr = REQ1_ADDR;
        req1.data = REQ1_DATA;
        sel       = grant[1] ? req1 : req0;
    end

    // Write stage: capture the granted write; zero-register writes are
    // accepted but never raise REG_WRITE. AW/DIN hold when nothing is granted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            AW        <= '0;
            DIN       <= '0;
            REG_WRITE <= 1'b0;
        end else begin
            REG_WRITE <= any_grant && (sel.addr != ZERO_REG);
            if (any_grant) begin
                AW  <= sel.addr;
                DIN <= sel.data;
            end
        end
    end

`ifdef REG_WB_BYPASS_EN
    // Forward the write reaching the bank this cycle to matching readers.
    always_comb begin
        BYP_HIT1  = REG_WRITE && (AW == RD_ADDR1) && (RD_ADDR1 != ZERO_REG);
        BYP_HIT2  = REG_WRITE && (AW == RD_ADDR2) && (RD_ADDR2 != ZERO_REG);
        BYP_DATA1 = BYP_HIT1 ? DIN : '0;
        BYP_DATA2 = BYP_HIT2 ? DIN : '0;
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed testbench for reg_wb_arbiter. Inputs change 1 ns after a rising
// edge; READY is sampled 1 ns later, registered outputs 1 ns after the edge.
module tb_reg_wb_arbiter;
    import reg_bank_pkg::*;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              FREEZE = 1'b0;
    logic              REQ0_VALID = 1'b0;
    logic [ADDR_W-1:0] REQ0_ADDR = '0;
    logic [DATA_W-1:0] REQ0_DATA = '0;
    logic              REQ0_READY;
    logic              REQ1_VALID = 1'b0;
    logic [ADDR_W-1:0] REQ1_ADDR = '0;
    logic [DATA_W-1:0] REQ1_DATA = '0;
    logic              REQ1_READY;
    logic [ADDR_W-1:0] AW;
    logic [DATA_W-1:0] DIN;
    logic              REG_WRITE;
`ifdef REG_WB_BYPASS_EN
    logic [ADDR_W-1:0] RD_ADDR1 = '0;
    logic [ADDR_W-1:0] RD_ADDR2 = '0;
    logic              BYP_HIT1;
    logic              BYP_HIT2;
    logic [DATA_W-1:0] BYP_DATA1;
    logic [DATA_W-1:0] BYP_DATA2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    reg_wb_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .FREEZE     (FREEZE),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .AW         (AW),
        .DIN        (DIN),
        .REG_WRITE  (REG_WRITE)
`ifdef REG_WB_BYPASS_EN
        ,
        .RD_ADDR1   (RD_ADDR1),
        .RD_ADDR2   (RD_ADDR2),
        .BYP_HIT1   (BYP_HIT1),
        .BYP_HIT2   (BYP_HIT2),
        .BYP_DATA1  (BYP_DATA1),
        .BYP_DATA2  (BYP_DATA2)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
        REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
    endtask

    // Held request during reset never sees READY; stage is clear after release.
    task automatic test_reset();
        RST = 1'b1;
        drive(1'b1, 5'd3, 32'hAAAA_0003, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({REQ1_READY, REQ0_READY} !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_ready[%0d]: got %b want 00", i, {REQ1_READY, REQ0_READY});
            end
            tick();
        end
        RST = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b0, 5'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_stage: got we=%b aw=%0d din=%h want we=0 aw=0 din=0", REG_WRITE, AW, DIN);
        end
    endtask

    // Both valid from reset: grants alternate 0,1,0,1, each requester
    // presenting its next item after a transfer.
    task automatic test_contention();
        logic [ADDR_W-1:0] a0 [4] = '{5'd1, 5'd2, 5'd2, 5'd2};
        logic [DATA_W-1:0] d0 [4] = '{32'h100, 32'h200, 32'h200, 32'h300};
        logic [ADDR_W-1:0] a1 [4] = '{5'd9, 5'd9, 5'd10, 5'd10};
        logic [DATA_W-1:0] d1 [4] = '{32'h900, 32'h900, 32'hA00, 32'hA00};
        logic [1:0]        eg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [ADDR_W-1:0] ea [4] = '{5'd1, 5'd9, 5'd2, 5'd10};
        logic [DATA_W-1:0] ed [4] = '{32'h100, 32'h900, 32'h200, 32'hA00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, a0[i], d0[i], 1'b1, a1[i], d1[i]);
            #1;
            vectors++;
            if ({REQ1_READY, REQ0_READY} !== eg[i]) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i, {REQ1_READY, REQ0_READY}, eg[i]);
            end
            tick();
            vectors++;
            if ({REG_WRITE, AW, DIN} !== {1'b1, ea[i], ed[i]}) begin
                miscompares++;
                $display("FAIL contention_write[%0d]: got we=%b aw=%0d din=%h want we=1 aw=%0d din=%h",
                         i, REG_WRITE, AW, DIN, ea[i], ed[i]);
            end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Same address written on consecutive cycles: both writes issue in order.
    task automatic test_back_to_back();
        logic [DATA_W-1:0] d [2] = '{32'h11, 32'h22};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd4, d[i], 1'b0, '0, '0);
            #1;
            vectors++;
            if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
                miscompares++;
                $display("FAIL b2b_grant[%0d]: got %b want 01", i, {REQ1_READY, REQ0_READY});
            end
            tick();
            vectors++;
            if ({REG_WRITE, AW, DIN} !== {1'b1, 5'd4, d[i]}) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: got we=%b aw=%0d din=%h want we=1 aw=4 din=%h",
                         i, REG_WRITE, AW, DIN, d[i]);
            end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Lone REQ1 is granted; idle cycle afterwards clears REG_WRITE, holds AW/DIN.
    task automatic test_single();
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        vectors++;
        if ({REQ1_READY, REQ0_READY} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 10", {REQ1_READY, REQ0_READY});
        end
        tick();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL single_write: got we=%b aw=%0d din=%h want we=1 aw=5 din=deadbeef", REG_WRITE, AW, DIN);
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL idle_hold: got we=%b aw=%0d din=%h want we=0 aw=5 din=deadbeef", REG_WRITE, AW, DIN);
        end
    endtask

    // Write to r0 is accepted but dropped; it still moves priority to REQ1.
    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0);
        #1;
        vectors++;
        if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_grant: got %b want 01", {REQ1_READY, REQ0_READY});
        end
        tick();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b0, 5'd0, 32'h1234}) begin
            miscompares++;
            $display("FAIL zero_write: got we=%b aw=%0d din=%h want we=0 aw=0 din=1234", REG_WRITE, AW, DIN);
        end
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
        #1;
        vectors++;
        if ({REQ1_READY, REQ0_READY} !== 2'b10) begin
            miscompares++;
            $display("FAIL zero_pri_flip: got %b want 10", {REQ1_READY, REQ0_READY});
        end
        tick();
        // REQ1 transferred; it goes idle, REQ0 keeps its pending write.
        drive(1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
    endtask

    // Frozen for 3 cycles: no grants, stage idles with AW/DIN held; on
    // release the grant follows the untouched pointer (REQ0), then REQ1.
    task automatic test_freeze();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b1, 5'd8, 32'h88}) begin
            miscompares++;
            $display("FAIL freeze_pre_write: got we=%b aw=%0d din=%h want we=1 aw=8 din=88", REG_WRITE, AW, DIN);
        end
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hCC);
        FREEZE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({REQ1_READY, REQ0_READY} !== 2'b00) begin
                miscompares++;
                $display("FAIL freeze_ready[%0d]: got %b want 00", i, {REQ1_READY, REQ0_READY});
            end
            tick();
            vectors++;
            if ({REG_WRITE, AW, DIN} !== {1'b0, 5'd8, 32'h88}) begin
                miscompares++;
                $display("FAIL freeze_stage[%0d]: got we=%b aw=%0d din=%h want we=0 aw=8 din=88",
                         i, REG_WRITE, AW, DIN);
            end
        end
        FREEZE = 1'b0;
        #1;
        vectors++;
        if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
            miscompares++;
            $display("FAIL freeze_release: got %b want 01", {REQ1_READY, REQ0_READY});
        end
        tick();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b1, 5'd6, 32'h66}) begin
            miscompares++;
            $display("FAIL freeze_release_write: got we=%b aw=%0d din=%h want we=1 aw=6 din=66", REG_WRITE, AW, DIN);
        end
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd12, 32'hCC);
        #1;
        vectors++;
        if ({REQ1_READY, REQ0_READY} !== 2'b10) begin
            miscompares++;
            $display("FAIL freeze_followup: got %b want 10", {REQ1_READY, REQ0_READY});
        end
        tick();
        vectors++;
        if ({REG_WRITE, AW, DIN} !== {1'b1, 5'd12, 32'hCC}) begin
            miscompares++;
            $display("FAIL freeze_followup_write: got we=%b aw=%0d din=%h want we=1 aw=12 din=cc", REG_WRITE, AW, DIN);
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

`ifdef REG_WB_BYPASS_EN
    // In-flight write to r7 is visible on port 1; r0 on port 2 never hits.
    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h55, 1'b0, '0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        RD_ADDR1 = 5'd7;
        RD_ADDR2 = 5'd0;
        #1;
        vectors++;
        if ({BYP_HIT1, BYP_DATA1} !== {1'b1, 32'h55}) begin
            miscompares++;
            $display("FAIL bypass_port1: got hit=%b data=%h want hit=1 data=55", BYP_HIT1, BYP_DATA1);
        end
        vectors++;
        if ({BYP_HIT2, BYP_DATA2} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL bypass_port2: got hit=%b data=%h want hit=0 data=0", BYP_HIT2, BYP_DATA2);
        end
        tick();
        vectors++;
        if ({BYP_HIT1, BYP_DATA1} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL bypass_idle: got hit=%b data=%h want hit=0 data=0", BYP_HIT1, BYP_DATA1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_back_to_back();
        test_single();
        test_zero_reg();
        test_freeze();
`ifdef REG_WB_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
